// File: rtl/mux_pipe_pkg.sv
// Shared types and the N:1 word-select helper for the write-back mux pipeline.
// The helper works on a maximum-sized bus; callers zero-pad their operands into it.
package mux_pipe_pkg;

    localparam int unsigned MAX_N_IN  = 16;
    localparam int unsigned MAX_WIDTH = 64;
    localparam int unsigned MAX_SEL_W = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef logic [MAX_N_IN*MAX_WIDTH-1:0] wide_bus_t;

    typedef struct packed {
        logic                 err;
        logic [MAX_WIDTH-1:0] word;
    } sel_res_t;

    // Out-of-range selects return a zero word with err set.
    function automatic sel_res_t sel_word(input wide_bus_t            data,
                                          input logic [MAX_SEL_W-1:0] sel,
                                          input logic [MAX_SEL_W:0]   n_in);
        sel_res_t res;
        res.err  = ({1'b0, sel} >= n_in);
        res.word = res.err ? '0 : data[sel*MAX_WIDTH +: MAX_WIDTH];
        return res;
    endfunction

endpackage

// File: rtl/mux_pipe_if.sv
// Upstream/downstream handshake bundle of the write-back mux pipeline.
interface mux_pipe_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N_IN  = 4
);
    localparam int unsigned SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    logic                  flush;
    logic [N_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]      in_sel;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_sel_err;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output flush, in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_sel_err, out_valid
    );

    modport slave (
        input  flush, in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_sel_err, out_valid
    );

endinterface

// File: rtl/mux_nto1.sv
// Combinational N:1 word select with range check; WIDTH up to 64, N_IN up to 16.
module mux_nto1
    import mux_pipe_pkg::*;
#(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned N_IN  = 4,
    localparam int unsigned SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic [N_IN*WIDTH-1:0] data,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      word_c,
    output logic                  err_c
);

    wide_bus_t padded;
    sel_res_t  res;

    // Re-stride the operands onto the helper's fixed word pitch.
    always_comb begin
        padded = '0;
        for (int k = 0; k < int'(N_IN); k++) begin
            padded[k*MAX_WIDTH +: MAX_WIDTH] = MAX_WIDTH'(data[k*WIDTH +: WIDTH]);
        end
    end

    assign res    = sel_word(padded, MAX_SEL_W'(sel), (MAX_SEL_W+1)'(N_IN));
    assign err_c  = res.err;
    assign word_c = WIDTH'(res.word);

endmodule

// File: rtl/mux_pipe.sv
// Registered N:1 write-back select with a one-word skid so in_ready is a flop.
// Output register plus skid register give full throughput under valid/ready.
module mux_pipe
    import mux_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N_IN  = 4
) (
    input  logic       Clk,
    input  logic       Reset_n,
    mux_pipe_if.slave  bus
);

    logic [WIDTH-1:0] word_c;
    logic             err_c;

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_err_q,   out_err_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             skid_err_q,  skid_err_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q,  in_ready_d;

    logic             accept_c;
    logic             emit_c;

    mux_nto1 #(
        .WIDTH (WIDTH),
        .N_IN  (N_IN)
    ) u_sel (
        .data   (bus.in_data),
        .sel    (bus.in_sel),
        .word_c (word_c),
        .err_c  (err_c)
    );

    assign accept_c = bus.in_valid & in_ready_q;
    assign emit_c   = out_valid_q & bus.out_ready;

    // Next-state and next-output values; flush overrides every transfer.
    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;

        if (bus.flush) begin
            state_d     = EMPTY;
            out_data_d  = '0;
            out_err_d   = 1'b0;
            skid_data_d = '0;
            skid_err_d  = 1'b0;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept_c) begin
                        state_d     = ONE;
                        out_data_d  = word_c;
                        out_err_d   = err_c;
                        out_valid_d = 1'b1;
                    end
                end
                ONE: begin
                    if (accept_c && emit_c) begin
                        out_data_d = word_c;
                        out_err_d  = err_c;
                    end else if (accept_c) begin
                        state_d     = FULL;
                        skid_data_d = word_c;
                        skid_err_d  = err_c;
                        in_ready_d  = 1'b0;
                    end else if (emit_c) begin
                        state_d     = EMPTY;
                        out_valid_d = 1'b0;
                    end
                end
                FULL: begin
                    if (emit_c) begin
                        state_d    = ONE;
                        out_data_d = skid_data_q;
                        out_err_d  = skid_err_q;
                        in_ready_d = 1'b1;
                    end
                end
                default: begin
                    state_d     = EMPTY;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= EMPTY;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.out_data    = out_data_q;
    assign bus.out_sel_err = out_err_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.in_ready    = in_ready_q;

endmodule

// File: tb/tb_mux_pipe.sv
// Bench for mux_pipe: N_IN=2, 4 and 3 instances driven in lockstep from one stimulus,
// each with its own expected-word queue drained by a monitor on the falling edge.
module tb_mux_pipe;

    typedef struct packed {
        logic [15:0] d;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] data;
    logic [1:0]  sel;
    logic        valid;
    logic        ready;
    logic        flush_r;

    exp_t exp_q [3][$];
    exp_t cur   [3];
    int   n_checks = 0;
    int   n_fails  = 0;

    // Streaming table: sel k over words 0001..0004 (N=2 sees sel[0], N=3 errors on 3).
    logic [15:0] st_e2  [4] = '{16'h0001, 16'h0002, 16'h0001, 16'h0002};
    logic [15:0] st_e4  [4] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    logic [15:0] st_e3  [4] = '{16'h0001, 16'h0002, 16'h0003, 16'h0000};
    logic        st_er3 [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    mux_pipe_if #(.WIDTH(16), .N_IN(2)) bus2 ();
    mux_pipe_if #(.WIDTH(16), .N_IN(4)) bus4 ();
    mux_pipe_if #(.WIDTH(16), .N_IN(3)) bus3 ();

    assign bus2.in_data = data[31:0];
    assign bus2.in_sel  = sel[0];
    assign bus4.in_data = data;
    assign bus4.in_sel  = sel;
    assign bus3.in_data = data[47:0];
    assign bus3.in_sel  = sel;

    assign bus2.in_valid = valid;
    assign bus4.in_valid = valid;
    assign bus3.in_valid = valid;
    assign bus2.out_ready = ready;
    assign bus4.out_ready = ready;
    assign bus3.out_ready = ready;
    assign bus2.flush = flush_r;
    assign bus4.flush = flush_r;
    assign bus3.flush = flush_r;

    mux_pipe #(.WIDTH(16), .N_IN(2)) u_dut2 (.Clk(clk), .Reset_n(rst_n), .bus(bus2));
    mux_pipe #(.WIDTH(16), .N_IN(4)) u_dut4 (.Clk(clk), .Reset_n(rst_n), .bus(bus4));
    mux_pipe #(.WIDTH(16), .N_IN(3)) u_dut3 (.Clk(clk), .Reset_n(rst_n), .bus(bus3));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    task automatic idle_check(input string tag);
        check({tag, "_valid2"}, 32'(bus2.out_valid), 32'd0);
        check({tag, "_valid4"}, 32'(bus4.out_valid), 32'd0);
        check({tag, "_valid3"}, 32'(bus3.out_valid), 32'd0);
        check({tag, "_ready2"}, 32'(bus2.in_ready), 32'd1);
        check({tag, "_ready4"}, 32'(bus4.in_ready), 32'd1);
        check({tag, "_ready3"}, 32'(bus3.in_ready), 32'd1);
    endtask

    task automatic set_word(input logic [63:0] d, input logic [1:0] s,
                            input logic [15:0] e2, input logic [15:0] e4,
                            input logic [15:0] e3, input logic err3);
        data   = d;
        sel    = s;
        cur[0] = '{d: e2, e: 1'b0};
        cur[1] = '{d: e4, e: 1'b0};
        cur[2] = '{d: e3, e: err3};
    endtask

    task automatic set_one(input logic [15:0] w);
        set_word({48'h0, w}, 2'd0, w, w, w, 1'b0);
    endtask

    // One clock: decide accept/flush on the falling edge, record it at the rising edge.
    task automatic cycle();
        logic acc;
        logic fl;
        @(negedge clk);
        acc = valid && bus4.in_ready && !flush_r && rst_n;
        fl  = flush_r;
        @(posedge clk);
        if (fl) begin
            for (int i = 0; i < 3; i++) exp_q[i].delete();
        end else if (acc) begin
            for (int i = 0; i < 3; i++) exp_q[i].push_back(cur[i]);
        end
        #1;
    endtask

    task automatic mon_one(input int i, input logic v, input logic [15:0] d, input logic e);
        exp_t x;
        if (v && ready && !flush_r) begin
            if (exp_q[i].size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_out[%0d]: actual %h required no word", i, d);
            end else begin
                x = exp_q[i].pop_front();
                check($sformatf("out_data[%0d]", i), 32'(d), 32'(x.d));
                check($sformatf("out_sel_err[%0d]", i), 32'(e), 32'(x.e));
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        valid   = 1'b0;
        ready   = 1'b0;
        flush_r = 1'b0;
        set_one(16'h0000);

        fork
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    mon_one(0, bus2.out_valid, bus2.out_data, bus2.out_sel_err);
                    mon_one(1, bus4.out_valid, bus4.out_data, bus4.out_sel_err);
                    mon_one(2, bus3.out_valid, bus3.out_data, bus3.out_sel_err);
                end
            end
        join_none

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        idle_check("reset");
        check("reset_data4", 32'(bus4.out_data), 32'd0);
        check("reset_err3", 32'(bus3.out_sel_err), 32'd0);
        rst_n = 1'b1;

        // Mid-stream asynchronous reset
        ready = 1'b1;
        valid = 1'b1;
        set_one(16'h7777);
        cycle();
        cycle();
        #2;
        rst_n = 1'b0;
        valid = 1'b0;
        for (int i = 0; i < 3; i++) exp_q[i].delete();
        #1;
        idle_check("async_reset");
        check("async_reset_data2", 32'(bus2.out_data), 32'd0);
        @(posedge clk);
        #1;
        idle_check("held_reset");
        rst_n = 1'b1;

        // Legacy 2:1 behaviour, one-cycle latency
        valid = 1'b1;
        set_word(64'h0000_0000_BEEF_1234, 2'd0, 16'h1234, 16'h1234, 16'h1234, 1'b0);
        cycle();
        check("legacy0_valid", 32'(bus2.out_valid), 32'd1);
        check("legacy0_data", 32'(bus2.out_data), 32'h1234);
        set_word(64'h0000_0000_BEEF_1234, 2'd1, 16'hBEEF, 16'hBEEF, 16'hBEEF, 1'b0);
        cycle();
        check("legacy1_data", 32'(bus2.out_data), 32'hBEEF);

        // Streaming at full rate
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                set_word(64'h0004_0003_0002_0001, 2'(k), st_e2[k], st_e4[k], st_e3[k], st_er3[k]);
                cycle();
                check("stream_in_ready", 32'(bus4.in_ready), 32'd1);
                check("stream_out_valid", 32'(bus4.out_valid), 32'd1);
                check("stream_lat_data4", 32'(bus4.out_data), 32'(st_e4[k]));
            end
        end
        valid = 1'b0;
        cycle();
        cycle();
        idle_check("stream_drained");

        // Backpressure into the skid
        ready = 1'b0;
        valid = 1'b1;
        set_one(16'hA5A5);
        cycle();
        set_one(16'h5A5A);
        cycle();
        valid = 1'b0;
        check("bp_state", 32'(u_dut4.state_q), 32'(mux_pipe_pkg::FULL));
        check("bp_in_ready", 32'(bus4.in_ready), 32'd0);
        check("bp_out_valid", 32'(bus4.out_valid), 32'd1);
        check("bp_out_data", 32'(bus4.out_data), 32'hA5A5);
        repeat (3) begin
            cycle();
            check("bp_hold_data", 32'(bus4.out_data), 32'hA5A5);
            check("bp_hold_ready", 32'(bus4.in_ready), 32'd0);
        end
        ready = 1'b1;
        cycle();
        check("bp_ready_back", 32'(bus4.in_ready), 32'd1);
        check("bp_skid_data", 32'(bus4.out_data), 32'h5A5A);
        cycle();
        idle_check("bp_drained");

        // Out-of-range select on the 3-input instance
        valid = 1'b1;
        set_word(64'hDDDD_CCCC_BBBB_AAAA, 2'd3, 16'hBBBB, 16'hDDDD, 16'h0000, 1'b1);
        cycle();
        check("selerr_flag", 32'(bus3.out_sel_err), 32'd1);
        check("selerr_data", 32'(bus3.out_data), 32'd0);
        set_word(64'hDDDD_CCCC_BBBB_AAAA, 2'd1, 16'hBBBB, 16'hBBBB, 16'hBBBB, 1'b0);
        cycle();
        check("selok_flag", 32'(bus3.out_sel_err), 32'd0);
        check("selok_data", 32'(bus3.out_data), 32'hBBBB);
        valid = 1'b0;
        cycle();
        cycle();

        // Flush while FULL, with input and output handshakes asserted
        ready = 1'b0;
        valid = 1'b1;
        set_one(16'h1111);
        cycle();
        set_one(16'h2222);
        cycle();
        check("flush_pre_full", 32'(bus4.in_ready), 32'd0);
        set_one(16'h3333);
        flush_r = 1'b1;
        ready   = 1'b1;
        cycle();
        flush_r = 1'b0;
        valid   = 1'b0;
        idle_check("flush_full");
        cycle();
        cycle();
        idle_check("flush_full_after");

        // Flush while ONE, where accept and emit would both have fired
        ready = 1'b0;
        valid = 1'b1;
        set_one(16'h4444);
        cycle();
        set_one(16'h5555);
        flush_r = 1'b1;
        ready   = 1'b1;
        cycle();
        flush_r = 1'b0;
        valid   = 1'b0;
        idle_check("flush_one");

        // Recovery after flush
        valid = 1'b1;
        set_one(16'h6666);
        cycle();
        valid = 1'b0;
        check("recover_data", 32'(bus4.out_data), 32'h6666);
        cycle();

        for (int t = 0; t < 20; t++) begin
            if (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() == 0) break;
            cycle();
        end
        check("drain_left", 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
